// File: rtl/core_ctrl.sv
// Instruction sequencer for the weight-stationary core: one tile per start pulse
// (weights -> L0 -> PEs, activations -> L0, execute, drain OFIFO -> pmem), plus idle host xmem writes.
module core_ctrl #(
  parameter int bw  = 4,
  parameter int row = 8,
  parameter int col = 8,
  parameter int aw  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [aw-1:0]     w_base,
  input  logic [aw-1:0]     a_base,
  input  logic [aw-1:0]     p_base,
  input  logic [aw-1:0]     n_act,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [aw-1:0]     host_addr,
  input  logic [row*bw-1:0] host_data,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic [row*bw-1:0] D_xmem,
  output logic              busy,
  output logic              done
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  localparam int CEN_P  = 32;
  localparam int WEN_P  = 31;
  localparam int CEN_X  = 19;
  localparam int WEN_X  = 18;
  localparam int OF_RD  = 6;
  localparam int L0_RD  = 3;
  localparam int L0_WR  = 2;
  localparam int EXE    = 1;
  localparam int LOAD   = 0;

  localparam logic [aw-1:0] ONE       = aw'(1);
  localparam logic [aw-1:0] COL_K     = aw'(col);
  localparam logic [aw-1:0] LOAD_LAST = aw'(col + row - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WL0, S_WLOAD, S_AL0, S_EXEC, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [aw-1:0]     k, k_nxt;
  logic [aw-1:0]     w_q, a_q, p_q, n_q;
  logic              latch;
  logic [33:0]       inst_nxt;
  logic [row*bw-1:0] d_nxt;
  logic              done_nxt;

  assign busy          = (state != S_IDLE);
  assign host_wr_ready = (state == S_IDLE) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      k      <= '0;
      w_q    <= '0;
      a_q    <= '0;
      p_q    <= '0;
      n_q    <= '0;
      inst   <= IDLE_WORD;
      D_xmem <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      inst   <= inst_nxt;
      D_xmem <= d_nxt;
      done   <= done_nxt;
      if (latch) begin
        w_q <= w_base;
        a_q <= a_base;
        p_q <= p_base;
        n_q <= n_act;
      end
    end
  end

  // The L0 write and the pmem write each trail their source by one cycle,
  // so the fill and drain states run one cycle longer than their word count.
  always_comb begin
    state_nxt = state;
    k_nxt     = '0;
    inst_nxt  = IDLE_WORD;
    d_nxt     = D_xmem;
    done_nxt  = 1'b0;
    latch     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          latch     = 1'b1;
          state_nxt = (n_act == '0) ? S_DONE : S_WL0;
        end else if (host_wr_valid) begin
          inst_nxt[CEN_X] = 1'b0;
          inst_nxt[WEN_X] = 1'b0;
          inst_nxt[17:7]  = host_addr;
          d_nxt           = host_data;
        end
      end
      S_WL0: begin
        if (k < COL_K) begin
          inst_nxt[CEN_X] = 1'b0;
          inst_nxt[17:7]  = w_q + k;
        end
        if (k != '0) inst_nxt[L0_WR] = 1'b1;
        if (k == COL_K) state_nxt = S_WLOAD;
        else            k_nxt     = k + ONE;
      end
      S_WLOAD: begin
        inst_nxt[L0_RD] = 1'b1;
        inst_nxt[LOAD]  = 1'b1;
        if (k == LOAD_LAST) state_nxt = S_AL0;
        else                k_nxt     = k + ONE;
      end
      S_AL0: begin
        if (k < n_q) begin
          inst_nxt[CEN_X] = 1'b0;
          inst_nxt[17:7]  = a_q + k;
        end
        if (k != '0) inst_nxt[L0_WR] = 1'b1;
        if (k == n_q) state_nxt = S_EXEC;
        else          k_nxt     = k + ONE;
      end
      S_EXEC: begin
        inst_nxt[L0_RD] = 1'b1;
        inst_nxt[EXE]   = 1'b1;
        if (k == n_q - ONE) state_nxt = S_WAIT;
        else                k_nxt     = k + ONE;
      end
      S_WAIT: begin
        if (ofifo_valid) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (k < n_q) inst_nxt[OF_RD] = 1'b1;
        if (k != '0) begin
          inst_nxt[CEN_P] = 1'b0;
          inst_nxt[WEN_P] = 1'b0;
          inst_nxt[30:20] = p_q + k - ONE;
        end
        if (k == n_q) state_nxt = S_DONE;
        else          k_nxt     = k + ONE;
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // At most one memory port may be enabled in any issued word.
  a_one_mem: assert property (@(posedge clk) disable iff (reset)
    !(!inst[CEN_X] && !inst[CEN_P]));

  a_done_idle: assert property (@(posedge clk) disable iff (reset)
    done |-> !busy);

endmodule
